// File: rtl/sv_enh_cmp_pkg.sv
// sv_enh_cmp_pkg: shared constants, flag bundle and range helper
// for the sv_enhanced_comparator decode stage.
package sv_enh_cmp_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_R1_LO  = 3;
  localparam int DEF_R1_HI  = 7;
  localparam int DEF_S2_A   = 2;
  localparam int DEF_S2_B   = 5;
  localparam int DEF_S2_C   = 9;
  localparam int DEF_R3_LO  = 10;
  localparam int DEF_R3_HI  = 15;
  localparam int DEF_CNT_W  = 8;

  typedef struct packed {
    logic r1;
    logic r2;
    logic r3;
    logic none;
  } cmp_flags_t;

  function automatic logic in_rng(
    input int unsigned value,
    input int unsigned lo,
    input int unsigned hi
  );
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/sv_enh_cmp_range_chk.sv
// sv_enh_cmp_range_chk: combinational inclusive [LO:HI] check
// on an unsigned sample.
module sv_enh_cmp_range_chk
  import sv_enh_cmp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LO     = 0,
  parameter int HI     = 0
) (
  input  logic [DATA_W-1:0] data,
  output logic              hit
);

  localparam int unsigned LO_U = LO;
  localparam int unsigned HI_U = HI;

  assign hit = in_rng(32'(data), LO_U, HI_U);

endmodule

// File: rtl/sv_enhanced_comparator.sv
// sv_enhanced_comparator: registered two-range / one-set classifier.
// Define SV_ENH_CMP_STATS_EN to add saturating per-flag hit counters.
module sv_enhanced_comparator
  import sv_enh_cmp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int R1_LO  = DEF_R1_LO,
  parameter int R1_HI  = DEF_R1_HI,
  parameter int S2_A   = DEF_S2_A,
  parameter int S2_B   = DEF_S2_B,
  parameter int S2_C   = DEF_S2_C,
  parameter int R3_LO  = DEF_R3_LO,
  parameter int R3_HI  = DEF_R3_HI,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data,
`ifdef SV_ENH_CMP_STATS_EN
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  hit_cnt1,
  output logic [CNT_W-1:0]  hit_cnt2,
  output logic [CNT_W-1:0]  hit_cnt3,
`endif
  output logic              valid_out,
  output logic              in_range1,
  output logic              in_range2,
  output logic              in_range3,
  output logic              in_none
);

  localparam longint MAXV = longint'(1) << DATA_W;

  if (R1_LO > R1_HI) begin : g_bad_r1
    $fatal(1, "sv_enhanced_comparator: R1_LO > R1_HI");
  end
  if (R3_LO > R3_HI) begin : g_bad_r3
    $fatal(1, "sv_enhanced_comparator: R3_LO > R3_HI");
  end
  if (longint'(R1_LO) >= MAXV || longint'(R1_HI) >= MAXV ||
      longint'(R3_LO) >= MAXV || longint'(R3_HI) >= MAXV ||
      longint'(S2_A)  >= MAXV || longint'(S2_B)  >= MAXV ||
      longint'(S2_C)  >= MAXV) begin : g_bad_w
    $fatal(1, "sv_enhanced_comparator: bound exceeds DATA_W");
  end

  cmp_flags_t cur;
  cmp_flags_t flags_q;
  logic       valid_q;
  logic       hit1;
  logic       hit3;

  sv_enh_cmp_range_chk #(
    .DATA_W (DATA_W),
    .LO     (R1_LO),
    .HI     (R1_HI)
  ) u_r1 (
    .data (data),
    .hit  (hit1)
  );

  sv_enh_cmp_range_chk #(
    .DATA_W (DATA_W),
    .LO     (R3_LO),
    .HI     (R3_HI)
  ) u_r3 (
    .data (data),
    .hit  (hit3)
  );

  // Classify the incoming sample; flags may overlap.
  always_comb begin
    cur      = '0;
    cur.r1   = hit1;
    cur.r2   = (data == DATA_W'(S2_A)) ||
               (data == DATA_W'(S2_B)) ||
               (data == DATA_W'(S2_C));
    cur.r3   = hit3;
    cur.none = ~(cur.r1 | cur.r2 | cur.r3);
  end

  // Capture flags on valid samples, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) flags_q <= cur;
    end
  end

  assign valid_out = valid_q;
  assign in_range1 = flags_q.r1;
  assign in_range2 = flags_q.r2;
  assign in_range3 = flags_q.r3;
  assign in_none   = flags_q.none;

`ifdef SV_ENH_CMP_STATS_EN
  logic [CNT_W-1:0] cnt_q [3];
  logic [2:0]       inc;

  assign inc = {3{valid_in}} & {cur.r3, cur.r2, cur.r1};

  // Saturating hit counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else if (clr_stats) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (inc[i] && (cnt_q[i] != '1))
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  assign hit_cnt1 = cnt_q[0];
  assign hit_cnt2 = cnt_q[1];
  assign hit_cnt3 = cnt_q[2];
`endif

endmodule

// File: tb/tb_sv_enhanced_comparator.sv
// tb_sv_enhanced_comparator: directed checks of the classifier
// flags, hold, reset and optional hit counters.
module tb_sv_enhanced_comparator;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [3:0]    data = '0;
  logic          valid_out;
  logic          in_range1;
  logic          in_range2;
  logic          in_range3;
  logic          in_none;
`ifdef SV_ENH_CMP_STATS_EN
  logic          clr_stats = 1'b0;
  logic [CW-1:0] hit_cnt1;
  logic [CW-1:0] hit_cnt2;
  logic [CW-1:0] hit_cnt3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // {r1,r2,r3,none} for values 0..15 with the default parameters
  logic [3:0] exp_tbl [16] = '{
    4'b0001, 4'b0001, 4'b0100, 4'b1000,
    4'b1000, 4'b1100, 4'b1000, 4'b1000,
    4'b0001, 4'b0100, 4'b0010, 4'b0010,
    4'b0010, 4'b0010, 4'b0010, 4'b0010
  };

  always #5 clk = ~clk;

  sv_enhanced_comparator #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data      (data),
`ifdef SV_ENH_CMP_STATS_EN
    .clr_stats (clr_stats),
    .hit_cnt1  (hit_cnt1),
    .hit_cnt2  (hit_cnt2),
    .hit_cnt3  (hit_cnt3),
`endif
    .valid_out (valid_out),
    .in_range1 (in_range1),
    .in_range2 (in_range2),
    .in_range3 (in_range3),
    .in_none   (in_none)
  );

  function automatic logic [3:0] flags();
    return {in_range1, in_range2, in_range3, in_none};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if ({valid_out, flags()} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_out got=%b want=00000",
               {valid_out, flags()});
    end
`ifdef SV_ENH_CMP_STATS_EN
    n_tests++;
    if ({hit_cnt1, hit_cnt2, hit_cnt3} !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt got=%h %h %h want=0 0 0",
               hit_cnt1, hit_cnt2, hit_cnt3);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 16; v++) begin
      data = 4'(v);
      valid_in = 1'b1;
      tick();
      n_tests++;
      if ({valid_out, flags()} !== {1'b1, exp_tbl[v]}) begin
        n_fail++;
        $display("FAIL sweep[%0d] got=%b want=%b", v,
                 {valid_out, flags()}, {1'b1, exp_tbl[v]});
      end
    end
  endtask

  task automatic test_boundaries();
    logic [3:0] vals [8] = '{4'd2, 4'd3, 4'd7, 4'd8,
                             4'd9, 4'd10, 4'd15, 4'd5};
    logic [3:0] exps [8] = '{4'b0100, 4'b1000, 4'b1000, 4'b0001,
                             4'b0100, 4'b0010, 4'b0010, 4'b1100};
    for (int i = 0; i < 8; i++) begin
      data = vals[i];
      valid_in = 1'b1;
      tick();
      n_tests++;
      if (flags() !== exps[i]) begin
        n_fail++;
        $display("FAIL bound[%0d] got=%b want=%b",
                 vals[i], flags(), exps[i]);
      end
    end
  endtask

  task automatic test_hold();
    data = 4'd12;
    valid_in = 1'b1;
    tick();
    n_tests++;
    if ({valid_out, flags()} !== 5'b10010) begin
      n_fail++;
      $display("FAIL hold_load got=%b want=10010",
               {valid_out, flags()});
    end
    data = 4'd0;
    valid_in = 1'b0;
    tick();
    n_tests++;
    if ({valid_out, flags()} !== 5'b00010) begin
      n_fail++;
      $display("FAIL hold_keep got=%b want=00010",
               {valid_out, flags()});
    end
    tick();
    n_tests++;
    if ({valid_out, flags()} !== 5'b00010) begin
      n_fail++;
      $display("FAIL hold_keep2 got=%b want=00010",
               {valid_out, flags()});
    end
  endtask

  task automatic test_async_reset();
    data = 4'd4;
    valid_in = 1'b1;
    tick();
    n_tests++;
    if ({valid_out, flags()} !== 5'b11000) begin
      n_fail++;
      $display("FAIL arst_pre got=%b want=11000",
               {valid_out, flags()});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({valid_out, flags()} !== 5'b0) begin
      n_fail++;
      $display("FAIL arst_now got=%b want=00000",
               {valid_out, flags()});
    end
    @(negedge clk);
    rst_n = 1'b1;
    data = 4'd9;
    valid_in = 1'b1;
    tick();
    n_tests++;
    if ({valid_out, flags()} !== 5'b10100) begin
      n_fail++;
      $display("FAIL arst_first got=%b want=10100",
               {valid_out, flags()});
    end
  endtask

`ifdef SV_ENH_CMP_STATS_EN
  task automatic test_saturate();
    logic [CW-1:0] want;
    clr_stats = 1'b1;
    valid_in = 1'b0;
    tick();
    clr_stats = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      data = 4'd5;
      valid_in = 1'b1;
      tick();
      want = (k >= 3) ? CW'(3) : CW'(k);
      n_tests++;
      if ({hit_cnt1, hit_cnt2, hit_cnt3} !== {want, want, CW'(0)}) begin
        n_fail++;
        $display("FAIL sat[%0d] got=%0d %0d %0d want=%0d %0d 0",
                 k, hit_cnt1, hit_cnt2, hit_cnt3, want, want);
      end
    end
  endtask

  task automatic test_clear_priority();
    data = 4'd11;
    valid_in = 1'b1;
    tick();
    n_tests++;
    if (hit_cnt3 !== CW'(1)) begin
      n_fail++;
      $display("FAIL clr_pre got=%0d want=1", hit_cnt3);
    end
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    n_tests++;
    if ({hit_cnt1, hit_cnt2, hit_cnt3, flags()} !==
        {CW'(0), CW'(0), CW'(0), 4'b0010}) begin
      n_fail++;
      $display("FAIL clr_win got=%0d %0d %0d %b want=0 0 0 0010",
               hit_cnt1, hit_cnt2, hit_cnt3, flags());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_boundaries();
    test_hold();
    test_async_reset();
`ifdef SV_ENH_CMP_STATS_EN
    test_saturate();
    test_clear_priority();
`endif
    valid_in = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
